blink6ram_arb: RTL

- Two-requester arbiter for port B of the 1 kW x 16 dual-port program/data RAM (blink6ram); port A stays dedicated to the CPU.
- Requester 0 is the host loader/debug path; requester 1 is a peripheral DMA path.
- Accepts at most one word access per clock with round-robin or fixed priority, registers the RAM command, and returns read data with a valid strobe tagged to the requester.

---
 rtl/blink6ram_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/blink6ram_arb.sv
// Port-B arbiter for blink6ram: two requesters, one registered RAM command per clock, tagged read return.
// Optional build macro RAM_CLR_EN: zero the whole RAM after reset release while busy is held high.
module blink6ram_arb #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_ack,
    output logic          m0_rv,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_ack,
    output logic          m1_rv,
    output logic [DW-1:0] m1_rd,
    output logic [AW-1:0] ab,
    output logic [DW-1:0] dib,
    output logic          ceb,
    output logic          web,
    input  logic [DW-1:0] dob,
    output logic          busy
);

    logic          busy_int;
    logic          clr_go;
    logic [AW-1:0] clr_addr;
    logic          last_srv;
    logic          gnt0;
    logic          gnt1;
    logic          gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wd;
    logic          tag_v;
    logic          tag_id;

`ifdef RAM_CLR_EN
    // state | meaning
    // CLR   | writing zero to clr_addr each clock, busy high, no acks
    // RUN   | normal arbitration
    typedef enum logic {S_CLR, S_RUN} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_CLR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLR)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLR && clr_addr == {AW{1'b1}})
            state_nxt = S_RUN;
    end

    assign clr_go   = (state == S_CLR);
    assign busy_int = rst && clr_go;
`else
    assign clr_go   = 1'b0;
    assign clr_addr = '0;
    assign busy_int = 1'b0;
`endif

    assign busy = busy_int;

    // last_srv = 1 means requester 1 was served last, so requester 0 wins the next tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && !busy_int) begin
            if (m0_req && m1_req) begin
                if (FIXED_PRI != 0 || last_srv)
                    gnt0 = 1'b1;
                else
                    gnt1 = 1'b1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign m0_ack   = gnt0;
    assign m1_ack   = gnt1;
    assign gnt_we   = gnt1 ? m1_we   : m0_we;
    assign gnt_addr = gnt1 ? m1_addr : m0_addr;
    assign gnt_wd   = gnt1 ? m1_wd   : m0_wd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab       <= '0;
            dib      <= '0;
            ceb      <= 1'b0;
            web      <= 1'b0;
            last_srv <= 1'b1;
            tag_v    <= 1'b0;
            tag_id   <= 1'b0;
            m0_rv    <= 1'b0;
            m1_rv    <= 1'b0;
        end else begin
            if (clr_go) begin
                ab  <= clr_addr;
                dib <= '0;
                ceb <= 1'b1;
                web <= 1'b1;
            end else if (gnt0 || gnt1) begin
                ab       <= gnt_addr;
                dib      <= gnt_wd;
                ceb      <= 1'b1;
                web      <= gnt_we;
                last_srv <= gnt1;
            end else begin
                ceb <= 1'b0;
                web <= 1'b0;
            end
            // tag follows the command one stage, then becomes the rv pulse as dob turns valid
            tag_v  <= (gnt0 || gnt1) && !gnt_we;
            tag_id <= gnt1;
            m0_rv  <= tag_v && !tag_id;
            m1_rv  <= tag_v && tag_id;
        end
    end

    assign m0_rd = dob;
    assign m1_rd = dob;

endmodule
